step4_normalize_pack: RTL
=========================

// Module: step4_normalize_pack
// PURPOSE
//  Post-add normalisation and IEEE-754 single packing for the floating MAC datapath.
//  Consumes the registered adder status (magnitude, carry, sign, pre-normalisation exponent).
//  Emits a packed 32-bit result plus overflow/underflow/zero flags.
//  Two-stage pipeline: A = leading-zero count and carry detect, B = shift, exponent adjust, exception handling and pack.
// PARAMETERS
//  MANT_W  24  adder magnitude width, hidden bit included (bit MANT_W-1)
//  EXP_W   8   exponent width; all-ones = Inf, bias 127
// PORTS
//  clock               in   1   rising-edge clock
//  resetn              in   1   asynchronous, active-low reset
//  in_valid            in   1   upstream sample valid this cycle
//  in_adder_out        in   24  adder magnitude, hidden-bit aligned
//  in_ov_sign          in   1   adder carry-out, already zeroed for effective subtraction
//  in_adder_out_sign   in   1   sign of the sum
//  in_current_ex       in   8   larger operand exponent, pre-normalisation
//  out_valid           out  1   out_result/flags valid
//  out_result          out  32  {sign, exp[7:0], frac[22:0]}
//  out_overflow        out  1   result saturated to +/-Inf
//  out_underflow       out  1   result flushed to signed zero
//  out_zero            out  1   exact zero (cancellation or zero input)
// BEHAVIOUR
//  Reset, async: all stage registers and all outputs = 0 (out_valid=0, out_result=32'h0, flags=0).
//  Latency: exactly 2 clocks from in_valid to out_valid.
//  No backpressure. Both stages advance every cycle. out_valid is in_valid delayed by 2.
//  Data registers load on every cycle, whatever the valid. Flags are forced to 0 when the stage valid = 0.
//  Stage A registers: mag, ov, sign, ex, lz = leading zeros of mag (0..24), is_zero = (mag==0 && !ov), is_inf_in = (ex==8'hFF).
//  Stage B cases, in priority order:
//   1. is_inf_in: result {sign, 8'hFF, 23'h0}; out_overflow=1.
//   2. is_zero: result 32'h0, with the sign forced to 0; out_zero=1.
//   3. ov=1: mant={1'b1, mag[23:1]}; exp=ex+1 (9-bit). If exp>=255, result {sign,8'hFF,23'h0} and out_overflow=1.
//   4. ov=0 and ex>lz: mant=mag<<lz; exp=ex-lz (always >=1).
//   5. ov=0 and ex<=lz: denormal case, flushed. Result {sign,31'h0}; out_underflow=1. This includes ex==0.
//  Fraction = mant[22:0]. Rounding is truncation, because upstream carries no guard, round or sticky bits.
//  At most one of out_overflow, out_underflow, out_zero is set per valid result.
//  Exponent arithmetic uses 9 bits. No wrap through 8'hFF or 8'h00 is allowed.
//  Back-to-back valids must not interact. A bubble (in_valid=0) gives out_valid=0 two cycles later.
//  resetn asserted mid-flight: in-flight samples are dropped. The first out_valid after release comes 2 cycles after the first in_valid.
// STRUCTURE
//  Shared package:
//   - FP32_EXP_INF = 8'hFF, FP32_BIAS = 127
//   - the typedef for the packed {sign, exp, frac} FP32 word
//   - the localparam for the lz width, $clog2(MANT_W+1)
//  Sub-module lzc24: combinational 24-bit leading-zero counter (priority tree), instantiated in stage A.
//  Everything else stays inline: two register banks plus the stage-B case logic.
// TESTING
//  1. adder_out=24'h800000, ov=0, ex=8'h7F, sign=0, valid=1
//     -> 2 cycles later result 32'h3F800000, all flags 0.
//  2. adder_out=24'h000000, ov=1, ex=8'h7F (1.0+1.0)
//     -> 32'h40000000; then ex=8'hFE, ov=1, sign=1 -> 32'hFF800000, out_overflow=1.
//  3. adder_out=24'h000001, ov=0, ex=8'h7F (deep cancellation, lz=23)
//     -> 32'h34000000.
//  4. adder_out=24'h000000, ov=0, sign=1
//     -> 32'h00000000, out_zero=1. Separately adder_out=24'h000100, ex=8'h05, sign=1 -> 32'h80000000, out_underflow=1.
//  5. Valid pattern 1,0,1,1 with distinct data
//     -> out_valid 0,0,1,0,1,1 with matching results, no cross-contamination.
//  6. Assert resetn low while 2 samples are in flight
//     -> outputs 0 immediately (async), no stale result after release.

Source files
------------

// File: rtl/step4_normalize_pack_pkg.sv
// Shared types and constants for the FP32 normalise-and-pack stage of the floating MAC.
package step4_normalize_pack_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned LZ_W   = $clog2(MANT_W + 1);

    localparam logic [EXP_W-1:0] FP32_EXP_INF = 8'hFF;
    localparam int unsigned      FP32_BIAS    = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] frac;
    } fp32_t;

endpackage

// File: rtl/step4_normalize_pack_lzc24.sv
// Combinational leading-zero counter for the 24-bit adder magnitude; all-zero input gives 24.
module step4_normalize_pack_lzc24
    import step4_normalize_pack_pkg::*;
(
    input  logic [MANT_W-1:0] mag_i,
    output logic [LZ_W-1:0]   lz_o
);

    // Two-level priority tree: pick the first non-zero nibble, then count within it.
    localparam int unsigned NumNib = MANT_W / 4;

    logic [NumNib-1:0] nib_nz;
    logic [1:0]        nib_lz [NumNib];

    always_comb begin
        for (int n = 0; n < NumNib; n++) begin
            nib_nz[n] = |mag_i[4*n +: 4];
            if (mag_i[4*n+3])      nib_lz[n] = 2'd0;
            else if (mag_i[4*n+2]) nib_lz[n] = 2'd1;
            else if (mag_i[4*n+1]) nib_lz[n] = 2'd2;
            else                   nib_lz[n] = 2'd3;
        end
    end

    always_comb begin
        lz_o = LZ_W'(MANT_W);
        for (int n = 0; n < NumNib; n++) begin
            // Lowest nibble first so the most significant non-zero nibble wins.
            if (nib_nz[n]) begin
                lz_o = LZ_W'(4 * (NumNib - 1 - n)) + LZ_W'(nib_lz[n]);
            end
        end
    end

endmodule

// File: rtl/step4_normalize_pack.sv
// Post-add normalisation and IEEE-754 single packing: stage A detects leading zeros and carry,
// stage B shifts, adjusts the exponent, handles Inf/zero/flush and packs the result.
module step4_normalize_pack
    import step4_normalize_pack_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [MANT_W-1:0] in_adder_out,
    input  logic              in_ov_sign,
    input  logic              in_adder_out_sign,
    input  logic [EXP_W-1:0]  in_current_ex,
    output logic              out_valid,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_zero
);

    logic [LZ_W-1:0] lz_comb;

    step4_normalize_pack_lzc24 u_lzc (
        .mag_i (in_adder_out),
        .lz_o  (lz_comb)
    );

    // Stage A registers
    logic              valid_a_q, valid_a_d;
    logic [MANT_W-1:0] mag_a_q, mag_a_d;
    logic              ov_a_q, ov_a_d;
    logic              sign_a_q, sign_a_d;
    logic [EXP_W-1:0]  ex_a_q, ex_a_d;
    logic [LZ_W-1:0]   lz_a_q, lz_a_d;
    logic              zero_a_q, zero_a_d;
    logic              inf_a_q, inf_a_d;

    always_comb begin
        valid_a_d = in_valid;
        mag_a_d   = in_adder_out;
        ov_a_d    = in_ov_sign;
        sign_a_d  = in_adder_out_sign;
        ex_a_d    = in_current_ex;
        lz_a_d    = lz_comb;
        zero_a_d  = (in_adder_out == '0) && !in_ov_sign;
        inf_a_d   = (in_current_ex == FP32_EXP_INF);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_a_q <= 1'b0;
            mag_a_q   <= '0;
            ov_a_q    <= 1'b0;
            sign_a_q  <= 1'b0;
            ex_a_q    <= '0;
            lz_a_q    <= '0;
            zero_a_q  <= 1'b0;
            inf_a_q   <= 1'b0;
        end else begin
            valid_a_q <= valid_a_d;
            mag_a_q   <= mag_a_d;
            ov_a_q    <= ov_a_d;
            sign_a_q  <= sign_a_d;
            ex_a_q    <= ex_a_d;
            lz_a_q    <= lz_a_d;
            zero_a_q  <= zero_a_d;
            inf_a_q   <= inf_a_d;
        end
    end

    // Stage B: normalise, handle exceptions, pack
    fp32_t              result_q, result_d;
    logic               valid_b_q, valid_b_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               zero_b_q, zero_b_d;
    logic               ovf_raw, udf_raw, zero_raw;
    logic [EXP_W:0]     exp_inc;
    logic [EXP_W-1:0]   exp_sub;
    logic [MANT_W-2:0]  frac_shl;

    always_comb begin
        exp_inc  = {1'b0, ex_a_q} + (EXP_W + 1)'(1);
        // Only used when ex > lz, so the 8-bit difference cannot wrap.
        exp_sub  = ex_a_q - EXP_W'(lz_a_q);
        frac_shl = (MANT_W - 1)'(mag_a_q << lz_a_q);

        result_d = '0;
        ovf_raw  = 1'b0;
        udf_raw  = 1'b0;
        zero_raw = 1'b0;

        if (inf_a_q) begin
            result_d.sign = sign_a_q;
            result_d.exp  = FP32_EXP_INF;
            ovf_raw       = 1'b1;
        end else if (zero_a_q) begin
            zero_raw = 1'b1;
        end else if (ov_a_q) begin
            result_d.sign = sign_a_q;
            if (exp_inc >= (EXP_W + 1)'(FP32_EXP_INF)) begin
                result_d.exp = FP32_EXP_INF;
                ovf_raw      = 1'b1;
            end else begin
                result_d.exp  = exp_inc[EXP_W-1:0];
                result_d.frac = mag_a_q[MANT_W-1:1];
            end
        end else if ({1'b0, ex_a_q} > (EXP_W + 1)'(lz_a_q)) begin
            result_d.sign = sign_a_q;
            result_d.exp  = exp_sub;
            result_d.frac = frac_shl;
        end else begin
            result_d.sign = sign_a_q;
            udf_raw       = 1'b1;
        end

        valid_b_d = valid_a_q;
        ovf_d     = ovf_raw  & valid_a_q;
        udf_d     = udf_raw  & valid_a_q;
        zero_b_d  = zero_raw & valid_a_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result_q  <= '0;
            valid_b_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            zero_b_q  <= 1'b0;
        end else begin
            result_q  <= result_d;
            valid_b_q <= valid_b_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            zero_b_q  <= zero_b_d;
        end
    end

    assign out_valid     = valid_b_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = udf_q;
    assign out_zero      = zero_b_q;

endmodule
